// File: rtl/fpa_operand_gen.sv
// Class-targeted IEEE-754 single operand pair generator feeding the fpa core.
// A follows a latched class, B sweeps ZERO/SUB/NORM/INF/NAN; fields come from two Galois LFSRs.
module fpa_operand_gen #(
  parameter logic [31:0] SEED    = 32'hACE1_2345,
  parameter int unsigned COUNT_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [2:0]         class_sel,
  input  logic [COUNT_W-1:0] num_pairs,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [31:0]        number_A,
  output logic [31:0]        number_B,
  output logic [COUNT_W-1:0] pair_idx,
  output logic               busy,
  output logic               done
);

  localparam logic [31:0] SEED_B   = SEED ^ 32'h5A5A_5A5A;
  localparam logic [31:0] LFSR_TAP = 32'h8020_0003;

  typedef enum logic [1:0] {
    S_IDLE,
    S_GEN,
    S_DONE
  } state_t;

  typedef enum logic [2:0] {
    C_ZERO = 3'd0,
    C_INF  = 3'd1,
    C_NAN  = 3'd2,
    C_SUB  = 3'd3,
    C_NORM = 3'd4
  } cls_t;

  state_t               state_q, state_d;
  logic [2:0]           cls_q, cls_d;
  logic [COUNT_W-1:0]   npairs_q, npairs_d;
  logic [COUNT_W-1:0]   idx_q, idx_d;
  logic [31:0]          lfsr_a_q, lfsr_a_d;
  logic [31:0]          lfsr_b_q, lfsr_b_d;
  logic [2:0]           b_cls_q, b_cls_d;
  logic [31:0]          num_a_q, num_a_d;
  logic [31:0]          num_b_q, num_b_d;

  logic [31:0]          lfsr_a_step;
  logic [31:0]          lfsr_b_step;
  logic [2:0]           b_cls_nxt;
  logic                 last_pair;

  function automatic logic [31:0] lfsr_next(input logic [31:0] w);
    lfsr_next = (w >> 1) ^ (w[0] ? LFSR_TAP : 32'h0);
  endfunction

  // B sweep order differs from the class_sel encoding.
  function automatic logic [2:0] b_class(input logic [2:0] idx);
    case (idx)
      3'd0:    b_class = C_ZERO;
      3'd1:    b_class = C_SUB;
      3'd2:    b_class = C_NORM;
      3'd3:    b_class = C_INF;
      default: b_class = C_NAN;
    endcase
  endfunction

  function automatic logic [31:0] shape(input logic [2:0] cls, input logic [31:0] w);
    logic        s;
    logic [7:0]  e;
    logic [22:0] m;
    logic [22:0] m_nz;
    s    = w[31];
    e    = w[30:23];
    m    = w[22:0];
    m_nz = (m == '0) ? 23'd1 : m;
    case (cls)
      C_ZERO:  shape = {s, 8'h00, 23'd0};
      C_INF:   shape = {s, 8'hFF, 23'd0};
      C_NAN:   shape = {s, 8'hFF, m_nz};
      C_SUB:   shape = {s, 8'h00, m_nz};
      default: begin
        if (e == 8'h00)      shape = {s, 8'h01, m};
        else if (e == 8'hFF) shape = {s, 8'hFE, m};
        else                 shape = {s, e, m};
      end
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cls_q    <= '0;
      npairs_q <= '0;
      idx_q    <= '0;
      lfsr_a_q <= SEED;
      lfsr_b_q <= SEED_B;
      b_cls_q  <= '0;
      num_a_q  <= '0;
      num_b_q  <= '0;
    end else begin
      state_q  <= state_d;
      cls_q    <= cls_d;
      npairs_q <= npairs_d;
      idx_q    <= idx_d;
      lfsr_a_q <= lfsr_a_d;
      lfsr_b_q <= lfsr_b_d;
      b_cls_q  <= b_cls_d;
      num_a_q  <= num_a_d;
      num_b_q  <= num_b_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cls_d       = cls_q;
    npairs_d    = npairs_q;
    idx_d       = idx_q;
    lfsr_a_d    = lfsr_a_q;
    lfsr_b_d    = lfsr_b_q;
    b_cls_d     = b_cls_q;
    num_a_d     = num_a_q;
    num_b_d     = num_b_q;
    lfsr_a_step = lfsr_next(lfsr_a_q);
    lfsr_b_step = lfsr_next(lfsr_b_q);
    b_cls_nxt   = (b_cls_q == 3'd4) ? 3'd0 : b_cls_q + 3'd1;
    last_pair   = (idx_q == npairs_q - 1'b1);

    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (class_sel <= 3'd4 && num_pairs != '0) begin
            state_d  = S_GEN;
            cls_d    = class_sel;
            npairs_d = num_pairs;
            idx_d    = '0;
            lfsr_a_d = SEED;
            lfsr_b_d = SEED_B;
            b_cls_d  = '0;
            num_a_d  = shape(class_sel, SEED);
            num_b_d  = shape(b_class(3'd0), SEED_B);
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_GEN: begin
        if (out_ready) begin
          // LFSRs and the B class step on every handshake; the last pair stays on the outputs.
          lfsr_a_d = lfsr_a_step;
          lfsr_b_d = lfsr_b_step;
          b_cls_d  = b_cls_nxt;
          if (last_pair) begin
            state_d = S_DONE;
          end else begin
            idx_d   = idx_q + 1'b1;
            num_a_d = shape(cls_q, lfsr_a_step);
            num_b_d = shape(b_class(b_cls_nxt), lfsr_b_step);
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign out_valid = (state_q == S_GEN);
  assign busy      = (state_q == S_GEN);
  assign done      = (state_q == S_DONE);
  assign number_A  = num_a_q;
  assign number_B  = num_b_q;
  assign pair_idx  = idx_q;

endmodule

// File: tb/tb_fpa_operand_gen.sv
// Directed self-checking bench for fpa_operand_gen: per-pair reference model plus class-property checks.
module tb_fpa_operand_gen;

  localparam logic [31:0] SEED   = 32'hACE1_2345;
  localparam logic [31:0] SEED_B = 32'hF6BB_791F;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [2:0]  class_sel;
  logic [15:0] num_pairs;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] number_A;
  logic [31:0] number_B;
  logic [15:0] pair_idx;
  logic        busy;
  logic        done;

  int checks   = 0;
  int failures = 0;

  logic [31:0] h1, h2, h3;

  fpa_operand_gen #(.SEED(32'hACE1_2345), .COUNT_W(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .class_sel (class_sel),
    .num_pairs (num_pairs),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .number_A  (number_A),
    .number_B  (number_B),
    .pair_idx  (pair_idx),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] m_step(input logic [31:0] w);
    m_step = (w >> 1) ^ (w[0] ? 32'h8020_0003 : 32'h0);
  endfunction

  function automatic logic [2:0] m_bcls(input int k);
    logic [2:0] tbl [5];
    tbl = '{3'd0, 3'd3, 3'd4, 3'd1, 3'd2};
    m_bcls = tbl[k];
  endfunction

  function automatic logic [31:0] m_shape(input logic [2:0] c, input logic [31:0] w);
    logic [7:0]  e;
    logic [22:0] m;
    e = w[30:23];
    m = w[22:0];
    case (c)
      3'd0: m_shape = {w[31], 31'h0};
      3'd1: m_shape = {w[31], 8'hFF, 23'h0};
      3'd2: m_shape = {w[31], 8'hFF, (m == 0) ? 23'd1 : m};
      3'd3: m_shape = {w[31], 8'h00, (m == 0) ? 23'd1 : m};
      default: m_shape = {w[31], (e == 0) ? 8'h01 : (e == 8'hFF) ? 8'hFE : e, m};
    endcase
  endfunction

  // Independent class membership test on a finished word.
  function automatic logic cls_ok(input logic [2:0] c, input logic [31:0] v);
    logic [7:0]  e;
    logic [22:0] m;
    e = v[30:23];
    m = v[22:0];
    case (c)
      3'd0: cls_ok = (e == 8'h00) && (m == 0);
      3'd1: cls_ok = (e == 8'hFF) && (m == 0);
      3'd2: cls_ok = (e == 8'hFF) && (m != 0);
      3'd3: cls_ok = (e == 8'h00) && (m != 0);
      default: cls_ok = (e != 8'h00) && (e != 8'hFF);
    endcase
  endfunction

  task automatic run(input logic [2:0] cls, input int n, input int stall_at, input int stall_len,
                     input int restart_at, output logic [31:0] hash);
    logic [31:0] ma, mb, ea, eb;
    int bc;
    ma = SEED;
    mb = SEED_B;
    bc = 0;
    hash = '0;
    class_sel = cls;
    num_pairs = 16'(n);
    out_ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < n; i++) begin
      ea = m_shape(cls, ma);
      eb = m_shape(m_bcls(bc), mb);
      chk("valid", {63'd0, out_valid}, 64'd1);
      chk("busy", {63'd0, busy}, 64'd1);
      chk("idx", {48'd0, pair_idx}, 64'(i));
      chk("A", {32'd0, number_A}, {32'd0, ea});
      chk("B", {32'd0, number_B}, {32'd0, eb});
      chk("A_class", {63'd0, cls_ok(cls, number_A)}, 64'd1);
      chk("B_class", {63'd0, cls_ok(m_bcls(bc), number_B)}, 64'd1);
      if (i == stall_at) begin
        out_ready = 1'b0;
        for (int s = 0; s < stall_len; s++) begin
          tick();
          chk("stall_valid", {63'd0, out_valid}, 64'd1);
          chk("stall_A", {32'd0, number_A}, {32'd0, ea});
          chk("stall_B", {32'd0, number_B}, {32'd0, eb});
          chk("stall_idx", {48'd0, pair_idx}, 64'(i));
        end
        out_ready = 1'b1;
      end
      if (i == restart_at) begin
        start = 1'b1;
        num_pairs = 16'(n + 7);
      end
      hash = {hash[30:0], hash[31]} ^ number_A ^ {number_B[15:0], number_B[31:16]};
      tick();
      start = 1'b0;
      ma = m_step(ma);
      mb = m_step(mb);
      bc = (bc == 4) ? 0 : bc + 1;
    end
    chk("end_done", {63'd0, done}, 64'd1);
    chk("end_busy", {63'd0, busy}, 64'd0);
    chk("end_valid", {63'd0, out_valid}, 64'd0);
    chk("end_A_hold", {32'd0, number_A}, {32'd0, m_shape(cls, m_step(ma) == 0 ? 0 : ea)});
    chk("end_idx_hold", {48'd0, pair_idx}, 64'(n - 1));
    tick();
    chk("idle_done", {63'd0, done}, 64'd0);
    chk("idle_valid", {63'd0, out_valid}, 64'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    class_sel = '0;
    num_pairs = '0;
    out_ready = 1'b0;
    tick();
    tick();
    chk("rst_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_done", {63'd0, done}, 64'd0);
    chk("rst_A", {32'd0, number_A}, 64'd0);
    chk("rst_B", {32'd0, number_B}, 64'd0);
    chk("rst_idx", {48'd0, pair_idx}, 64'd0);
    rst_n = 1'b1;
    tick();

    // T1: hand-computed first pair, then full model run
    class_sel = 3'd0;
    num_pairs = 16'd5;
    out_ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("t1_A0", {32'd0, number_A}, 64'h8000_0000);
    chk("t1_B0", {32'd0, number_B}, 64'h8000_0000);
    tick();
    chk("t1_B1", {32'd0, number_B}, 64'h807D_BC8C);
    repeat (5) tick();
    run(3'd0, 5, -1, 0, -1, h1);

    // T2: NaN class for A
    run(3'd2, 64, -1, 0, -1, h1);

    // T3: normals, repeatability, and NORM seed pair passes through unchanged
    class_sel = 3'd4;
    num_pairs = 16'd1;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("t3_A0", {32'd0, number_A}, 64'hACE1_2345);
    tick();
    tick();
    run(3'd4, 1000, -1, 0, -1, h1);
    run(3'd4, 1000, -1, 0, -1, h2);
    chk("t3_repeat", {32'd0, h2}, {32'd0, h1});

    // T4: stall at pair 2 gives same sequence
    run(3'd4, 8, -1, 0, -1, h1);
    run(3'd4, 8, 2, 3, -1, h2);
    chk("t4_stall_seq", {32'd0, h2}, {32'd0, h1});

    // T5: empty / invalid runs, and start while busy
    class_sel = 3'd1;
    num_pairs = 16'd0;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("t5_n0_done", {63'd0, done}, 64'd1);
    chk("t5_n0_valid", {63'd0, out_valid}, 64'd0);
    tick();
    chk("t5_n0_done_off", {63'd0, done}, 64'd0);
    chk("t5_n0_valid2", {63'd0, out_valid}, 64'd0);
    class_sel = 3'd6;
    num_pairs = 16'd4;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("t5_cls6_done", {63'd0, done}, 64'd1);
    chk("t5_cls6_valid", {63'd0, out_valid}, 64'd0);
    tick();
    chk("t5_cls6_done_off", {63'd0, done}, 64'd0);
    run(3'd3, 6, -1, 0, 1, h1);

    // T6: reset mid-run then replay
    run(3'd4, 10, -1, 0, -1, h1);
    class_sel = 3'd4;
    num_pairs = 16'd10;
    out_ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    h3 = number_A;
    repeat (3) tick();
    chk("t6_idx3", {48'd0, pair_idx}, 64'd3);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("t6_rst_valid", {63'd0, out_valid}, 64'd0);
    chk("t6_rst_busy", {63'd0, busy}, 64'd0);
    chk("t6_rst_done", {63'd0, done}, 64'd0);
    chk("t6_rst_A", {32'd0, number_A}, 64'd0);
    chk("t6_rst_B", {32'd0, number_B}, 64'd0);
    chk("t6_rst_idx", {48'd0, pair_idx}, 64'd0);
    tick();
    chk("t6_idle", {63'd0, busy}, 64'd0);
    run(3'd4, 10, -1, 0, -1, h2);
    chk("t6_replay", {32'd0, h2}, {32'd0, h1});
    chk("t6_pair0", {32'd0, h3}, 64'hACE1_2345);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
